traffic_sequencer: RTL and testbench

- Upstream controller FSM for the two-road intersection. It produces the 3-bit `current_state` and the `emerg_active` flag consumed by `light_driver`.
- Sequences main/side green, yellow and all-red phases from a 1 Hz tick enable.
- Serves side-road demand from a vehicle sensor.
- Handles an emergency request with yellow clearance before the forced all-red hold.

---
 rtl/traffic_pkg.sv | 32 +++
 rtl/sync_2ff.sv | 22 ++
 rtl/traffic_sequencer.sv | 132 +++++++++++++
 tb/tb_traffic_sequencer.sv | 395 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// Shared phase codes, road directions and default phase timings for the
// two-road intersection controller and its light driver.
package traffic_pkg;

  localparam logic [2:0] ST_ALL_RED    = 3'd0;
  localparam logic [2:0] ST_MAIN_GREEN = 3'd1;
  localparam logic [2:0] ST_MAIN_YEL   = 3'd2;
  localparam logic [2:0] ST_SIDE_GREEN = 3'd3;
  localparam logic [2:0] ST_SIDE_YEL   = 3'd4;
  localparam logic [2:0] ST_EMERGENCY  = 3'd5;

  typedef enum logic [2:0] {
    ALL_RED    = ST_ALL_RED,
    MAIN_GREEN = ST_MAIN_GREEN,
    MAIN_YEL   = ST_MAIN_YEL,
    SIDE_GREEN = ST_SIDE_GREEN,
    SIDE_YEL   = ST_SIDE_YEL,
    EMERGENCY  = ST_EMERGENCY
  } state_t;

  localparam logic DIR_MAIN = 1'b0;
  localparam logic DIR_SIDE = 1'b1;

  localparam int DEF_T_ALL_RED     = 2;
  localparam int DEF_T_MAIN_GREEN  = 10;
  localparam int DEF_T_MAIN_YEL    = 3;
  localparam int DEF_T_SIDE_GREEN  = 6;
  localparam int DEF_T_SIDE_YEL    = 3;
  localparam int DEF_T_EMERG_CLEAR = 2;
  localparam int DEF_TW            = 8;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level input; both flops
// clear to 0 on reset.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/traffic_sequencer.sv
// Intersection phase sequencer: timed main/side green-yellow-all-red cycle
// driven by a tick enable, side-road demand latching and emergency override.
module traffic_sequencer
  import traffic_pkg::*;
#(
  parameter int T_ALL_RED     = DEF_T_ALL_RED,
  parameter int T_MAIN_GREEN  = DEF_T_MAIN_GREEN,
  parameter int T_MAIN_YEL    = DEF_T_MAIN_YEL,
  parameter int T_SIDE_GREEN  = DEF_T_SIDE_GREEN,
  parameter int T_SIDE_YEL    = DEF_T_SIDE_YEL,
  parameter int T_EMERG_CLEAR = DEF_T_EMERG_CLEAR,
  parameter int TW            = DEF_TW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          tick,
  input  logic          side_req,
  input  logic          emerg_req,
  output logic [2:0]    current_state,
  output logic          emerg_active,
  output logic [TW-1:0] time_left,
  output logic          side_pending
);

  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          dir_q, dir_d;
  logic          pend_d;
  logic          side_sync, esync;
  logic          expire;
  logic          side_entry;

  sync_2ff u_sync_side (
    .clk (clk),
    .rst (rst),
    .d   (side_req),
    .q   (side_sync)
  );

  sync_2ff u_sync_emerg (
    .clk (clk),
    .rst (rst),
    .d   (emerg_req),
    .q   (esync)
  );

  // Timer reload value for a phase: the phase lasts exactly T_x ticks.
  function automatic logic [TW-1:0] phase_len(input state_t s);
    case (s)
      MAIN_GREEN: phase_len = TW'(T_MAIN_GREEN - 1);
      MAIN_YEL:   phase_len = TW'(T_MAIN_YEL - 1);
      SIDE_GREEN: phase_len = TW'(T_SIDE_GREEN - 1);
      SIDE_YEL:   phase_len = TW'(T_SIDE_YEL - 1);
      EMERGENCY:  phase_len = TW'(T_EMERG_CLEAR - 1);
      default:    phase_len = TW'(T_ALL_RED - 1);
    endcase
  endfunction

  assign expire = tick && (timer_q == '0);

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    timer_d = (tick && (timer_q != '0)) ? timer_q - TW'(1) : timer_q;
    case (state_q)
      ALL_RED: begin
        if (esync)       state_d = EMERGENCY;
        else if (expire) state_d = (dir_q == DIR_MAIN) ? MAIN_GREEN : SIDE_GREEN;
      end
      MAIN_GREEN: begin
        // Without side demand an expired green simply holds at time_left 0.
        if (esync || (expire && side_pending)) state_d = MAIN_YEL;
      end
      MAIN_YEL: begin
        if (expire) begin
          if (esync) begin
            state_d = EMERGENCY;
          end else begin
            state_d = ALL_RED;
            dir_d   = DIR_SIDE;
          end
        end
      end
      SIDE_GREEN: begin
        if (esync || expire) state_d = SIDE_YEL;
      end
      SIDE_YEL: begin
        if (expire) begin
          if (esync) begin
            state_d = EMERGENCY;
          end else begin
            state_d = ALL_RED;
            dir_d   = DIR_MAIN;
          end
        end
      end
      EMERGENCY: begin
        if (esync) begin
          timer_d = phase_len(EMERGENCY);
        end else if (expire) begin
          state_d = ALL_RED;
          dir_d   = DIR_MAIN;
        end
      end
      default: state_d = ALL_RED;
    endcase
    if (state_d != state_q) timer_d = phase_len(state_d);
    // A fresh side request on the entry edge keeps the demand latched.
    side_entry = (state_d == SIDE_GREEN) && (state_q != SIDE_GREEN);
    pend_d     = side_sync | (side_pending & ~side_entry);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ALL_RED;
      timer_q      <= TW'(T_ALL_RED - 1);
      dir_q        <= DIR_MAIN;
      side_pending <= 1'b0;
      emerg_active <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      dir_q        <= dir_d;
      side_pending <= pend_d;
      emerg_active <= (state_d == EMERGENCY);
    end
  end

  assign current_state = state_q;
  assign time_left     = timer_q;

endmodule

// File: tb/tb_traffic_sequencer.sv
// Self-checking bench for traffic_sequencer: directed scenarios plus a random
// run, all compared against a phase/ticks-remaining reference model.
module tb_traffic_sequencer;

  localparam int TAR = 2;
  localparam int TMG = 10;
  localparam int TMY = 3;
  localparam int TSG = 6;
  localparam int TSY = 3;
  localparam int TEC = 2;
  localparam int TW  = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          tick = 1'b0;
  logic          side_req = 1'b0;
  logic          emerg_req = 1'b0;
  logic [2:0]    current_state;
  logic          emerg_active;
  logic [TW-1:0] time_left;
  logic          side_pending;
  logic [TW+4:0] dut_vec;

  int checks = 0;
  int failures = 0;

  traffic_sequencer #(
    .T_ALL_RED     (TAR),
    .T_MAIN_GREEN  (TMG),
    .T_MAIN_YEL    (TMY),
    .T_SIDE_GREEN  (TSG),
    .T_SIDE_YEL    (TSY),
    .T_EMERG_CLEAR (TEC),
    .TW            (TW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .tick          (tick),
    .side_req      (side_req),
    .emerg_req     (emerg_req),
    .current_state (current_state),
    .emerg_active  (emerg_active),
    .time_left     (time_left),
    .side_pending  (side_pending)
  );

  always #5 clk = ~clk;

  assign dut_vec = {current_state, emerg_active, time_left, side_pending};

  // Reference model: phase number, whole ticks remaining in the phase,
  // which green comes after the next all-red, latched demand.
  int       m_phase = 0;
  int       m_rem = TAR;
  bit       m_side_next = 1'b0;
  bit       m_pend = 1'b0;
  bit       m_ea = 1'b0;
  bit [1:0] e_hist = 2'b00;
  bit [1:0] s_hist = 2'b00;

  function automatic int dur(input int p);
    case (p)
      1:       return TMG;
      2:       return TMY;
      3:       return TSG;
      4:       return TSY;
      5:       return TEC;
      default: return TAR;
    endcase
  endfunction

  function automatic void model_reset();
    m_phase = 0; m_rem = TAR; m_side_next = 1'b0; m_pend = 1'b0; m_ea = 1'b0;
    e_hist = 2'b00; s_hist = 2'b00;
  endfunction

  function automatic void model_step();
    bit es, ss, done;
    int nxt;
    es = e_hist[1];
    ss = s_hist[1];
    e_hist = {e_hist[0], emerg_req};
    s_hist = {s_hist[0], side_req};
    done = tick && (m_rem == 1);
    nxt = m_phase;
    case (m_phase)
      0: if (es) nxt = 5; else if (done) nxt = m_side_next ? 3 : 1;
      1: if (es || (done && m_pend)) nxt = 2;
      2: if (done) begin nxt = es ? 5 : 0; m_side_next = 1'b1; end
      3: if (es || done) nxt = 4;
      4: if (done) begin nxt = es ? 5 : 0; m_side_next = 1'b0; end
      default: if (!es && done) begin nxt = 0; m_side_next = 1'b0; end
    endcase
    if (nxt != m_phase)            m_rem = dur(nxt);
    else if (nxt == 5 && es)       m_rem = TEC;
    else if (tick && m_rem > 1)    m_rem = m_rem - 1;
    if (ss)                              m_pend = 1'b1;
    else if (nxt == 3 && m_phase != 3)   m_pend = 1'b0;
    m_ea = (nxt == 5);
    m_phase = nxt;
  endfunction

  function automatic logic [TW+4:0] model_vec();
    logic [TW-1:0] tl;
    tl = TW'(m_rem - 1);
    return {m_phase[2:0], m_ea, tl, m_pend};
  endfunction

  // Called at a falling edge: apply inputs, step model on the rising edge.
  task automatic cyc(input bit t, input bit s, input bit e);
    tick = t; side_req = s; emerg_req = e;
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; tick = 1'b0; side_req = 1'b0; emerg_req = 1'b0;
    model_reset();
    @(negedge clk);
    rst = 1'b0; tick = 1'b1;
  endtask

  task automatic test_reset();
    int first_one;
    @(negedge clk);
    rst = 1'b1; tick = 1'b0; side_req = 1'b0; emerg_req = 1'b0;
    model_reset();
    #1;
    checks++;
    if (dut_vec !== {3'd0, 1'b0, TW'(TAR - 1), 1'b0}) begin
      failures++; $display("FAIL reset_values got=%h exp=%h", dut_vec, {3'd0, 1'b0, TW'(TAR - 1), 1'b0});
    end
    @(negedge clk);
    rst = 1'b0; tick = 1'b1;
    first_one = -1;
    for (int i = 0; i < 40; i++) begin
      cyc(1'b1, 1'b0, 1'b0);
      checks++;
      if (dut_vec !== model_vec()) begin
        failures++; $display("FAIL reset_seq cyc%0d got=%h exp=%h", i, dut_vec, model_vec());
      end
      if (first_one < 0 && current_state == 3'd1) first_one = i;
    end
    checks++;
    if (first_one !== 1) begin
      failures++; $display("FAIL reset_to_main_green got=%0d exp=1", first_one);
    end
    checks++;
    if (dut_vec !== {3'd1, 1'b0, TW'(0), 1'b0}) begin
      failures++; $display("FAIL main_green_hold got=%h exp=%h", dut_vec, {3'd1, 1'b0, TW'(0), 1'b0});
    end
  endtask

  task automatic test_side_demand();
    logic [2:0]  prev_st;
    logic [23:0] seq;
    int          side_run;
    bit          pend_at_entry;
    do_reset();
    prev_st = 3'd7; seq = '0; side_run = 0; pend_at_entry = 1'b1;
    for (int i = 0; i < 60; i++) begin
      cyc(1'b1, (i >= 4 && i < 7), 1'b0);
      checks++;
      if (dut_vec !== model_vec()) begin
        failures++; $display("FAIL side_seq cyc%0d got=%h exp=%h", i, dut_vec, model_vec());
      end
      if (current_state == 3'd3) begin
        if (prev_st != 3'd3) pend_at_entry = side_pending;
        side_run++;
      end
      if (current_state != prev_st) begin
        seq = {seq[20:0], current_state};
        prev_st = current_state;
      end
    end
    checks++;
    if (seq !== 24'o01203401) begin
      failures++; $display("FAIL side_phase_order got=%o exp=%o", seq, 24'o01203401);
    end
    checks++;
    if (side_run !== TSG) begin
      failures++; $display("FAIL side_green_len got=%0d exp=%0d", side_run, TSG);
    end
    checks++;
    if (pend_at_entry !== 1'b0) begin
      failures++; $display("FAIL side_pending_clear got=%b exp=0", pend_at_entry);
    end
  endtask

  task automatic test_emergency();
    bit found;
    int first2, first5, first0, first1;
    bit ea_at5;
    do_reset();
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      cyc(1'b1, 1'b0, 1'b0);
      checks++;
      if (dut_vec !== model_vec()) begin
        failures++; $display("FAIL emerg_pre cyc%0d got=%h exp=%h", i, dut_vec, model_vec());
      end
      if (current_state == 3'd1 && time_left == TW'(6)) found = 1'b1;
    end
    checks++;
    if (!found) begin
      failures++; $display("FAIL emerg_wait_green got=timeout exp=time_left_6");
    end
    first2 = -1; first5 = -1; ea_at5 = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      cyc(1'b1, 1'b0, 1'b1);
      checks++;
      if (dut_vec !== model_vec()) begin
        failures++; $display("FAIL emerg_on cyc%0d got=%h exp=%h", i, dut_vec, model_vec());
      end
      if (first2 < 0 && current_state == 3'd2) first2 = i;
      if (first5 < 0 && current_state == 3'd5) begin first5 = i; ea_at5 = emerg_active; end
    end
    checks++;
    if (first2 !== 3) begin failures++; $display("FAIL emerg_to_yellow got=%0d exp=3", first2); end
    checks++;
    if (first5 !== 6) begin failures++; $display("FAIL emerg_entry got=%0d exp=6", first5); end
    checks++;
    if (ea_at5 !== 1'b1) begin failures++; $display("FAIL emerg_active got=%b exp=1", ea_at5); end
    first0 = -1; first1 = -1;
    for (int i = 1; i <= 12; i++) begin
      cyc(1'b1, 1'b0, 1'b0);
      checks++;
      if (dut_vec !== model_vec()) begin
        failures++; $display("FAIL emerg_off cyc%0d got=%h exp=%h", i, dut_vec, model_vec());
      end
      if (first0 < 0 && current_state == 3'd0) first0 = i;
      if (first1 < 0 && current_state == 3'd1) first1 = i;
    end
    checks++;
    if (first0 !== 4) begin failures++; $display("FAIL emerg_clear_len got=%0d exp=4", first0); end
    checks++;
    if (first1 !== 6) begin failures++; $display("FAIL emerg_back_green got=%0d exp=6", first1); end
  endtask

  task automatic test_slow_tick();
    int first_run [8];
    logic [2:0] prev_st;
    int cur;
    do_reset();
    foreach (first_run[k]) first_run[k] = -1;
    prev_st = 3'd7; cur = 0;
    for (int i = 0; i < 200; i++) begin
      cyc((i % 4) == 0, 1'b1, 1'b0);
      checks++;
      if (dut_vec !== model_vec()) begin
        failures++; $display("FAIL slow_tick cyc%0d got=%h exp=%h", i, dut_vec, model_vec());
      end
      if (current_state == prev_st) begin
        cur++;
      end else begin
        if (first_run[prev_st] < 0) first_run[prev_st] = cur;
        cur = 1;
        prev_st = current_state;
      end
    end
    checks++;
    if (first_run[1] !== 4 * TMG) begin failures++; $display("FAIL slow_main_green got=%0d exp=%0d", first_run[1], 4 * TMG); end
    checks++;
    if (first_run[2] !== 4 * TMY) begin failures++; $display("FAIL slow_main_yel got=%0d exp=%0d", first_run[2], 4 * TMY); end
    checks++;
    if (first_run[3] !== 4 * TSG) begin failures++; $display("FAIL slow_side_green got=%0d exp=%0d", first_run[3], 4 * TSG); end
    for (int i = 0; i < 50; i++) begin
      cyc(1'b0, 1'b0, 1'b0);
      checks++;
      if (dut_vec !== model_vec()) begin
        failures++; $display("FAIL tick_freeze cyc%0d got=%h exp=%h", i, dut_vec, model_vec());
      end
    end
  endtask

  task automatic test_async_reset();
    bit found;
    do_reset();
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      cyc(1'b1, 1'b1, 1'b0);
      checks++;
      if (dut_vec !== model_vec()) begin
        failures++; $display("FAIL areset_pre cyc%0d got=%h exp=%h", i, dut_vec, model_vec());
      end
      if (current_state == 3'd3 && time_left == TW'(3)) found = 1'b1;
    end
    checks++;
    if (!found) begin
      failures++; $display("FAIL areset_wait_side got=timeout exp=side_green_tl3");
    end
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    checks++;
    if (dut_vec !== {3'd0, 1'b0, TW'(TAR - 1), 1'b0}) begin
      failures++; $display("FAIL async_reset got=%h exp=%h", dut_vec, {3'd0, 1'b0, TW'(TAR - 1), 1'b0});
    end
    @(negedge clk);
    rst = 1'b0; side_req = 1'b0;
  endtask

  task automatic test_emerg_all_red();
    bit seen2, found, saw_side;
    logic [2:0]  prev_st;
    logic [26:0] seq;
    do_reset();
    seen2 = 1'b0; found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      cyc(1'b1, (i >= 3 && i < 6), 1'b0);
      checks++;
      if (dut_vec !== model_vec()) begin
        failures++; $display("FAIL ar_pre cyc%0d got=%h exp=%h", i, dut_vec, model_vec());
      end
      if (current_state == 3'd2) seen2 = 1'b1;
      if (seen2 && current_state == 3'd0) found = 1'b1;
    end
    checks++;
    if (!found) begin
      failures++; $display("FAIL ar_wait_all_red got=timeout exp=all_red");
    end
    saw_side = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      cyc(1'b0, 1'b0, 1'b1);
      checks++;
      if (dut_vec !== model_vec()) begin
        failures++; $display("FAIL ar_emerg cyc%0d got=%h exp=%h", i, dut_vec, model_vec());
      end
      if (current_state == 3'd3) saw_side = 1'b1;
    end
    checks++;
    if ({current_state, saw_side, side_pending} !== {3'd5, 1'b0, 1'b1}) begin
      failures++; $display("FAIL ar_to_emerg got=%h exp=%h", {current_state, saw_side, side_pending}, {3'd5, 1'b0, 1'b1});
    end
    prev_st = 3'd7; seq = '0;
    for (int i = 0; i < 60; i++) begin
      cyc(1'b1, 1'b0, 1'b0);
      checks++;
      if (dut_vec !== model_vec()) begin
        failures++; $display("FAIL ar_release cyc%0d got=%h exp=%h", i, dut_vec, model_vec());
      end
      if (current_state != prev_st) begin
        seq = {seq[23:0], current_state};
        prev_st = current_state;
      end
    end
    checks++;
    if (seq !== 27'o501203401) begin
      failures++; $display("FAIL ar_release_order got=%o exp=%o", seq, 27'o501203401);
    end
  endtask

  task automatic test_random();
    int hold;
    bit s, e, t;
    do_reset();
    hold = 0; s = 1'b0; e = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (hold == 0) begin
        s = 1'($urandom_range(0, 1));
        e = ($urandom_range(0, 9) == 0);
        hold = int'($urandom_range(2, 14));
      end
      hold--;
      t = ($urandom_range(0, 3) != 0);
      cyc(t, s, e);
      checks++;
      if (dut_vec !== model_vec()) begin
        failures++; $display("FAIL random cyc%0d got=%h exp=%h", i, dut_vec, model_vec());
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_side_demand();
    test_emergency();
    test_slow_tick();
    test_async_reset();
    test_emerg_all_red();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
